npu_bus_master: RTL and testbench
=================================

Name: npu_bus_master

Overview:
- Initiator side of the NPU host bus (ena/wea/addra/dina/douta). Turns a stream of host commands into correctly timed NPU bus cycles.
- Command kinds: single write, single read, and poll-until-bit-set. Polling is used for done/valid flags.
- Sits between a CPU/DMA command source and the NPU slave port. Returns one response per command.

Parameters:
- POLL_TIMEOUT, 1024, max read attempts per POLL command; must be >= 1.
- CNT_W, 16, width of the attempt counter and rsp_count; must satisfy 2^CNT_W > POLL_TIMEOUT.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous reset, active-high.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  command accepted when cmd_valid&&cmd_ready.
- cmd_op  input  2  0=WRITE, 1=READ, 2=POLL, 3=reserved (treated as READ).
- cmd_addr  input  16  NPU address.
- cmd_data  input  32  write data (WRITE) or bit mask (POLL); ignored for READ.
- rsp_valid  output  1  response available.
- rsp_ready  input  1  response consumed when rsp_valid&&rsp_ready.
- rsp_data  output  32  read/poll data; 0 for WRITE.
- rsp_timeout  output  1  POLL ended without a mask hit.
- rsp_count  output  CNT_W  read attempts used (WRITE=0, READ=1).
- npu_ena  output  1  to NPU ena.
- npu_wea  output  1  to NPU wea.
- npu_addra  output  16  to NPU addra.
- npu_dina  output  32  to NPU dina.
- npu_douta  input  32  from NPU douta; registered in the NPU, valid the cycle after a read strobe.

Behaviour:
- All outputs registered. While rst=1 and after reset: npu_ena=0, npu_wea=0, npu_addra=0, npu_dina=0, rsp_valid=0, rsp_data=0, rsp_timeout=0, rsp_count=0, state=S_IDLE.
- cmd_ready = (state==S_IDLE) && !rst. It is combinational and is the only combinational output.
- States and transitions:
  - S_IDLE: on accept, latch op/addr/data and clear the attempt counter. Go to S_WR, S_RD_REQ, or S_PL_REQ according to op.
  - S_WR: npu_ena=1, npu_wea=1, addra/dina driven for exactly one cycle. Then go to S_RSP with rsp_data=0, rsp_count=0, rsp_timeout=0.
  - S_RD_REQ / S_PL_REQ: npu_ena=1, npu_wea=0, addra driven for one cycle, dina=0. Counter increments. Then go to S_RD_WAIT / S_PL_WAIT.
  - S_RD_WAIT: npu_ena=0; sample npu_douta into rsp_data; go to S_RSP.
  - S_PL_WAIT: npu_ena=0; sample npu_douta.
    - If (douta & mask) != 0: go to S_RSP, timeout=0.
    - Else if counter == POLL_TIMEOUT: go to S_RSP, timeout=1, rsp_data = last sample.
    - Else go back to S_PL_REQ.
  - S_RSP: rsp_valid=1, and rsp_data/rsp_timeout/rsp_count are held stable until rsp_ready. On handshake, rsp_valid drops next cycle and state returns to S_IDLE.
- npu_ena/npu_wea are low in every state except S_WR/S_*_REQ. No back-to-back strobes: there is at least one idle bus cycle between any two strobes.
- Latency from an accept on edge T:
  - WRITE: strobe in cycle T+1; rsp_valid in T+2.
  - READ: strobe in T+1; douta sampled in T+2; rsp_valid in T+3.
  - POLL hit on attempt n: rsp_valid in T+1+2n.
- A mask of 0 never hits, so POLL runs to timeout. This is legal.
- A new command is never accepted while a response is pending. rsp_ready asserted without rsp_valid is ignored.
- Reset asserted mid-operation: bus strobes drop immediately (asynchronous), the command is discarded, and no response is issued.
- The counter saturates at POLL_TIMEOUT; it never wraps.

Test Plan:
- WRITE addr=0x1000, data=0x00030201, rsp_ready=1 -> exactly one cycle with ena=1, wea=1, addra=0x1000, dina=0x00030201. Response rsp_data=0, count=0 two cycles after accept.
- READ addr=0x6000, NPU stub returns 0xDEADBEEF one cycle after the strobe -> one strobe with wea=0. rsp_data=0xDEADBEEF, count=1, rsp_valid three cycles after accept.
- POLL addr=0x5000, mask=0x1, stub returns 0,0,1 on successive reads -> exactly 3 read strobes, 2 cycles apart. rsp_data=1, count=3, timeout=0.
- POLL with POLL_TIMEOUT=4, stub always returns 0xFFFFFFFE, mask=0x1 -> 4 strobes. timeout=1, count=4, rsp_data=0xFFFFFFFE, and no 5th strobe.
- READ with rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_data stable, cmd_ready=0, no bus activity. Handshake then cmd_ready=1 next cycle.
- rst pulsed during S_PL_WAIT of a POLL -> ena, wea and rsp_valid go to 0 without waiting for a clock edge, no response emitted. The next READ after reset completes normally with count=1.

Source files
------------

// File: rtl/npu_bus_master_if.sv
// Command, response and NPU host-bus signals of npu_bus_master in one bundle.
// The master modport is the bus master's view; slave is the environment's view.
interface npu_bus_master_if #(
   parameter int CNT_W = 16
);
   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [15:0]      cmd_addr;
   logic [31:0]      cmd_data;
   logic             rsp_valid;
   logic             rsp_ready;
   logic [31:0]      rsp_data;
   logic             rsp_timeout;
   logic [CNT_W-1:0] rsp_count;
   logic             npu_ena;
   logic             npu_wea;
   logic [15:0]      npu_addra;
   logic [31:0]      npu_dina;
   logic [31:0]      npu_douta;

   modport master (
      input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready, npu_douta,
      output cmd_ready, rsp_valid, rsp_data, rsp_timeout, rsp_count,
             npu_ena, npu_wea, npu_addra, npu_dina
   );

   modport slave (
      output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready, npu_douta,
      input  cmd_ready, rsp_valid, rsp_data, rsp_timeout, rsp_count,
             npu_ena, npu_wea, npu_addra, npu_dina
   );
endinterface

// File: rtl/npu_bus_master.sv
// Turns WRITE / READ / POLL commands into NPU host-bus cycles, one response each.
// Every output except cmd_ready is a flop loaded from next-state values.
module npu_bus_master #(
   parameter int POLL_TIMEOUT = 1024,
   parameter int CNT_W        = 16
) (
   input logic              clk,
   input logic              rst,
   npu_bus_master_if.master bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_WR, S_RD_REQ, S_RD_WAIT, S_PL_REQ, S_PL_WAIT, S_RSP
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(POLL_TIMEOUT);

   state_t           state, state_n;
   logic [15:0]      addr_q, addr_n;
   logic [31:0]      data_q, data_n;
   logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
   logic             ena_q, ena_n, wea_q, wea_n;
   logic [15:0]      addra_q, addra_n;
   logic [31:0]      dina_q, dina_n;
   logic             rv_q, rv_n, rto_q, rto_n;
   logic [31:0]      rd_q, rd_n;
   logic [CNT_W-1:0] rc_q, rc_n;
   logic             cmd_ready;

   assign cmd_ready       = (state == S_IDLE) && !rst;
   assign bus.cmd_ready   = cmd_ready;
   assign bus.npu_ena     = ena_q;
   assign bus.npu_wea     = wea_q;
   assign bus.npu_addra   = addra_q;
   assign bus.npu_dina    = dina_q;
   assign bus.rsp_valid   = rv_q;
   assign bus.rsp_data    = rd_q;
   assign bus.rsp_timeout = rto_q;
   assign bus.rsp_count   = rc_q;

   // Saturating so a POLL can never wrap the attempt count.
   assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         cnt     <= '0;
         ena_q   <= 1'b0;
         wea_q   <= 1'b0;
         addra_q <= '0;
         dina_q  <= '0;
         rv_q    <= 1'b0;
         rto_q   <= 1'b0;
         rd_q    <= '0;
         rc_q    <= '0;
      end else begin
         state   <= state_n;
         addr_q  <= addr_n;
         data_q  <= data_n;
         cnt     <= cnt_n;
         ena_q   <= ena_n;
         wea_q   <= wea_n;
         addra_q <= addra_n;
         dina_q  <= dina_n;
         rv_q    <= rv_n;
         rto_q   <= rto_n;
         rd_q    <= rd_n;
         rc_q    <= rc_n;
      end
   end

   // Strobe values are set on the edge that enters a strobe state, so the bus
   // sees them exactly during that state's cycle.
   always_comb begin
      state_n = state;
      addr_n  = addr_q;
      data_n  = data_q;
      cnt_n   = cnt;
      ena_n   = 1'b0;
      wea_n   = 1'b0;
      addra_n = '0;
      dina_n  = '0;
      rv_n    = rv_q;
      rto_n   = rto_q;
      rd_n    = rd_q;
      rc_n    = rc_q;
      unique case (state)
         S_IDLE: begin
            if (bus.cmd_valid && cmd_ready) begin
               addr_n  = bus.cmd_addr;
               data_n  = bus.cmd_data;
               cnt_n   = '0;
               ena_n   = 1'b1;
               addra_n = bus.cmd_addr;
               case (bus.cmd_op)
                  2'd0: begin
                     state_n = S_WR;
                     wea_n   = 1'b1;
                     dina_n  = bus.cmd_data;
                  end
                  2'd2:    state_n = S_PL_REQ;
                  default: state_n = S_RD_REQ;
               endcase
            end
         end
         S_WR: begin
            state_n = S_RSP;
            rv_n    = 1'b1;
            rd_n    = '0;
            rc_n    = '0;
            rto_n   = 1'b0;
         end
         S_RD_REQ: begin
            cnt_n   = cnt_inc;
            state_n = S_RD_WAIT;
         end
         S_RD_WAIT: begin
            state_n = S_RSP;
            rv_n    = 1'b1;
            rd_n    = bus.npu_douta;
            rc_n    = cnt;
            rto_n   = 1'b0;
         end
         S_PL_REQ: begin
            cnt_n   = cnt_inc;
            state_n = S_PL_WAIT;
         end
         S_PL_WAIT: begin
            if ((bus.npu_douta & data_q) != '0 || cnt == CNT_MAX) begin
               state_n = S_RSP;
               rv_n    = 1'b1;
               rd_n    = bus.npu_douta;
               rc_n    = cnt;
               rto_n   = ((bus.npu_douta & data_q) == '0);
            end else begin
               state_n = S_PL_REQ;
               ena_n   = 1'b1;
               addra_n = addr_q;
            end
         end
         S_RSP: begin
            if (bus.rsp_ready) begin
               state_n = S_IDLE;
               rv_n    = 1'b0;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_npu_bus_master.sv
// Directed plus random commands against a queue-fed NPU stub; expected bus
// strobes, latency and responses come from a per-command outcome model.
module tb_npu_bus_master;
   localparam int TO    = 4;
   localparam int CNT_W = 16;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   logic prev_ena = 1'b0;

   typedef struct {
      int          cyc;
      logic        wea;
      logic [15:0] addr;
      logic [31:0] dina;
   } strobe_t;

   strobe_t     log_q[$];
   logic [31:0] rd_fifo[$];
   logic [31:0] vals[4];

   npu_bus_master_if #(.CNT_W(CNT_W)) bus ();

   npu_bus_master #(.POLL_TIMEOUT(TO), .CNT_W(CNT_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // NPU stub: logs every strobe, answers reads one cycle later from rd_fifo.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      prev_ena <= bus.npu_ena;
      if (bus.npu_ena) begin
         log_q.push_back('{cyc, bus.npu_wea, bus.npu_addra, bus.npu_dina});
         checks++;
         assert (!prev_ena) else begin
            errors++;
            $error("FAIL back_to_back observed=1 expected=0");
         end
         if (!bus.npu_wea)
            bus.npu_douta <= (rd_fifo.size() != 0) ? rd_fifo.pop_front() : 32'hA5A5_0000;
      end
   end

   task automatic run_cmd(input logic [1:0] op, input logic [15:0] addr,
                          input logic [31:0] data, input int hold);
      int n, strobes, lat, acc, waited;
      logic [31:0] ed;
      logic et, found;
      // Outcome model: attempts, data and timeout straight from the command rules.
      et = 1'b0; found = 1'b0;
      if (op == 2'd0) begin
         n = 0; ed = '0; strobes = 1; lat = 2;
      end else if (op == 2'd2) begin
         n = TO; ed = vals[TO-1]; et = 1'b1;
         for (int i = 0; i < TO; i++)
            if (!found && (vals[i] & data) != 0) begin
               found = 1'b1; n = i + 1; ed = vals[i]; et = 1'b0;
            end
         strobes = n; lat = 1 + 2 * n;
      end else begin
         n = 1; ed = vals[0]; strobes = 1; lat = 3;
      end
      log_q.delete();
      rd_fifo.delete();
      if (op == 2'd2) for (int i = 0; i < TO; i++) rd_fifo.push_back(vals[i]);
      else if (op != 2'd0) rd_fifo.push_back(vals[0]);

      @(negedge clk);
      chk("cmd_ready_idle", bus.cmd_ready, 1);
      bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_addr = addr; bus.cmd_data = data;
      bus.rsp_ready = (hold == 0);
      @(posedge clk);
      acc = cyc;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      waited = 0;
      while (!bus.rsp_valid && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      chk("rsp_arrived", bus.rsp_valid, 1);
      chk("latency", cyc - acc, lat);
      chk("rsp_data", bus.rsp_data, ed);
      chk("rsp_count", bus.rsp_count, n);
      chk("rsp_timeout", bus.rsp_timeout, et);
      for (int k = 0; k < hold; k++) begin
         chk("hold_valid", bus.rsp_valid, 1);
         chk("hold_data", bus.rsp_data, ed);
         chk("hold_ready", bus.cmd_ready, 0);
         chk("hold_ena", bus.npu_ena, 0);
         if (k == hold - 1) bus.rsp_ready = 1'b1;
         @(negedge clk);
      end
      @(posedge clk);
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      chk("rsp_dropped", bus.rsp_valid, 0);
      chk("ready_after", bus.cmd_ready, 1);
      chk("n_strobes", log_q.size(), strobes);
      for (int i = 0; i < log_q.size() && i < strobes; i++) begin
         chk("strobe_cyc", log_q[i].cyc, acc + 1 + 2 * i);
         chk("strobe_wea", log_q[i].wea, op == 2'd0);
         chk("strobe_addr", log_q[i].addr, addr);
         chk("strobe_dina", log_q[i].dina, (op == 2'd0) ? data : 32'h0);
      end
   endtask

   // Start a command, assert reset mid-flight after `neg` negedges, check the
   // outputs drop before any clock edge and that no response follows.
   task automatic reset_mid(input logic [1:0] op, input int neg, input logic exp_ena);
      rd_fifo.delete();
      for (int i = 0; i < TO; i++) rd_fifo.push_back(32'h0);
      @(negedge clk);
      bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_addr = 16'h5000; bus.cmd_data = 32'h1;
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      for (int i = 1; i < neg; i++) @(negedge clk);
      chk("pre_rst_ena", bus.npu_ena, exp_ena);
      #1 rst = 1'b1;
      #1;
      chk("rst_ena", bus.npu_ena, 0);
      chk("rst_wea", bus.npu_wea, 0);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_cmd_ready", bus.cmd_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk("post_rst_no_rsp", bus.rsp_valid, 0);
      end
      bus.rsp_ready = 1'b0;
      rd_fifo.delete();
   endtask

   initial begin
      logic [1:0]  op;
      logic [31:0] mask;
      int          h;
      bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_addr = '0; bus.cmd_data = '0;
      bus.rsp_ready = 1'b0; bus.npu_douta = '0;
      #2 rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("reset_ena", bus.npu_ena, 0);
      chk("reset_wea", bus.npu_wea, 0);
      chk("reset_addra", bus.npu_addra, 0);
      chk("reset_dina", bus.npu_dina, 0);
      chk("reset_rsp_valid", bus.rsp_valid, 0);
      chk("reset_rsp_data", bus.rsp_data, 0);
      chk("reset_rsp_count", bus.rsp_count, 0);
      chk("reset_cmd_ready", bus.cmd_ready, 0);
      rst = 1'b0;

      vals = '{32'h0, 32'h0, 32'h0, 32'h0};
      run_cmd(2'd0, 16'h1000, 32'h0003_0201, 0);
      vals = '{32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0};
      run_cmd(2'd1, 16'h6000, 32'h0, 0);
      vals = '{32'h0, 32'h0, 32'h1, 32'h0};
      run_cmd(2'd2, 16'h5000, 32'h1, 0);
      vals = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
      run_cmd(2'd2, 16'h5000, 32'h1, 1);
      vals = '{32'h1234_5678, 32'h0, 32'h0, 32'h0};
      run_cmd(2'd1, 16'h6004, 32'h0, 5);
      vals = '{32'hCAFE_F00D, 32'h0, 32'h0, 32'h0};
      run_cmd(2'd3, 16'h6008, 32'hFFFF_FFFF, 0);
      vals = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      run_cmd(2'd2, 16'h5004, 32'h0, 0);

      reset_mid(2'd2, 2, 1'b0);
      vals = '{32'h0BAD_CAFE, 32'h0, 32'h0, 32'h0};
      run_cmd(2'd1, 16'h6000, 32'h0, 0);
      reset_mid(2'd0, 1, 1'b1);
      vals = '{32'h0000_0042, 32'h0, 32'h0, 32'h0};
      run_cmd(2'd1, 16'h600C, 32'h0, 2);

      for (int t = 0; t < 24; t++) begin
         op   = 2'($urandom_range(0, 3));
         mask = ($urandom_range(0, 4) == 0) ? 32'h0 : $urandom;
         h    = $urandom_range(0, TO);
         for (int i = 0; i < TO; i++) vals[i] = $urandom & ~mask;
         if (h < TO) vals[h] = vals[h] | mask;
         if (op != 2'd2) vals[0] = $urandom;
         run_cmd(op, 16'($urandom), (op == 2'd2) ? mask : $urandom, $urandom_range(0, 3));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
